// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN processing-element feeder: accumulator
// width, default stream word size and the feeder state encoding.
package bnn_pkg;

  localparam int ACC_W             = 16;
  localparam int DEFAULT_WORD_SIZE = 64;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN,
    CAPTURE,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/bnn_tail_mask.sv
// Valid-bit mask for the last word of a vector: the low 'rem' bits set,
// or every bit set when the vector fills the last word exactly (rem == 0).
module bnn_tail_mask #(
  parameter int WORD_SIZE = 64,
  parameter int REM_W     = $clog2(WORD_SIZE)
) (
  input  logic [REM_W-1:0]     rem,
  output logic [WORD_SIZE-1:0] mask
);

  // Thermometer decode of the remainder.
  always_comb begin
    mask = '0;
    for (int i = 0; i < WORD_SIZE; i++) begin
      mask[i] = (rem == '0) || (i < int'(rem));
    end
  end

endmodule

// File: rtl/bnn_pe_feeder.sv
// Streams packed weight/activation words into an XNOR-popcount PE, masks the
// tail of the vector, drains the PE pipeline and captures the popcount.
// Optional feature: define BNN_FEEDER_DOT_EN to add the signed res_dot output
// (2*res_sum - len).
module bnn_pe_feeder
  import bnn_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int LEN_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [LEN_W-1:0]     start_len,
  input  logic                 rd_valid,
  output logic                 rd_ready,
  input  logic [WORD_SIZE-1:0] rd_weight,
  input  logic [WORD_SIZE-1:0] rd_activation,
  output logic                 pe_ce,
  output logic                 pe_accumulate,
  output logic [WORD_SIZE-1:0] pe_weight,
  output logic [WORD_SIZE-1:0] pe_activation,
  output logic [WORD_SIZE-1:0] pe_mask,
  input  logic [ACC_W-1:0]     pe_acc_sum,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_W-1:0]     res_sum
`ifdef BNN_FEEDER_DOT_EN
  ,
  output logic signed [LEN_W+1:0] res_dot
`endif
);

  localparam int CNT_W = LEN_W + 1;
  localparam int REM_W = $clog2(WORD_SIZE);

  feeder_state_t state, state_next;

  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     nwords_q;
  logic [LEN_W-1:0]     beat_cnt;
  logic [CNT_W-1:0]     len_round;
  logic [LEN_W-1:0]     nwords_next;
  logic [REM_W-1:0]     tail_rem;
  logic [WORD_SIZE-1:0] tail_mask;
  logic                 last_beat;

  // One extra bit keeps the round-up from wrapping near the maximum length.
  assign len_round   = CNT_W'(start_len) + CNT_W'(WORD_SIZE - 1);
  assign nwords_next = LEN_W'(len_round / CNT_W'(WORD_SIZE));
  assign tail_rem    = REM_W'(len_q % LEN_W'(WORD_SIZE));
  assign last_beat   = (beat_cnt == nwords_q - LEN_W'(1));

  bnn_tail_mask #(
    .WORD_SIZE (WORD_SIZE),
    .REM_W     (REM_W)
  ) u_tail_mask (
    .rem  (tail_rem),
    .mask (tail_mask)
  );

  // State register.
  // NOTE: reset is in the sensitivity list so it acts without a clock edge;
  // all sequential state uses non-blocking assignments to avoid update races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and PE/handshake outputs.
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next    = state;
    start_ready   = 1'b0;
    rd_ready      = 1'b0;
    pe_ce         = 1'b0;
    pe_accumulate = 1'b0;
    pe_weight     = '0;
    pe_activation = '0;
    pe_mask       = '0;
    res_valid     = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_next = (start_len == '0) ? DONE : STREAM;
      end
      STREAM: begin
        rd_ready = 1'b1;
        if (rd_valid) begin
          pe_ce         = 1'b1;
          pe_accumulate = (beat_cnt != '0);
          pe_weight     = rd_weight;
          pe_activation = rd_activation;
          pe_mask       = last_beat ? tail_mask : '1;
          if (last_beat) state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Zero-mask beat flushes the PE pipeline without adding anything.
        pe_ce         = 1'b1;
        pe_accumulate = 1'b1;
        state_next    = CAPTURE;
      end
      CAPTURE: state_next = DONE;
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Job length, beat counter and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q    <= '0;
      nwords_q <= '0;
      beat_cnt <= '0;
      res_sum  <= '0;
`ifdef BNN_FEEDER_DOT_EN
      res_dot  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            len_q    <= start_len;
            nwords_q <= nwords_next;
            beat_cnt <= '0;
            if (start_len == '0) begin
              res_sum <= '0;
`ifdef BNN_FEEDER_DOT_EN
              res_dot <= '0;
`endif
            end
          end
        end
        STREAM: begin
          if (rd_valid) beat_cnt <= beat_cnt + LEN_W'(1);
        end
        CAPTURE: begin
          res_sum <= pe_acc_sum;
`ifdef BNN_FEEDER_DOT_EN
          res_dot <= signed'(((LEN_W+2)'(pe_acc_sum) << 1) - (LEN_W+2)'(len_q));
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_pe_feeder.sv
// Directed bench for bnn_pe_feeder (WORD_SIZE=64) with a behavioural
// XNOR-popcount PE attached to the PE port.
module tb_bnn_pe_feeder;

  localparam int          WS   = 64;
  localparam int          LW   = 16;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_valid;
  logic          start_ready;
  logic [LW-1:0] start_len;
  logic          rd_valid;
  logic          rd_ready;
  logic [WS-1:0] rd_weight;
  logic [WS-1:0] rd_activation;
  logic          pe_ce;
  logic          pe_accumulate;
  logic [WS-1:0] pe_weight;
  logic [WS-1:0] pe_activation;
  logic [WS-1:0] pe_mask;
  logic [15:0]   pe_acc_sum;
  logic          res_valid;
  logic          res_ready;
  logic [15:0]   res_sum;
`ifdef BNN_FEEDER_DOT_EN
  logic signed [LW+1:0] res_dot;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bnn_pe_feeder #(.WORD_SIZE(WS), .LEN_W(LW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_valid   (start_valid),
    .start_ready   (start_ready),
    .start_len     (start_len),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_weight     (rd_weight),
    .rd_activation (rd_activation),
    .pe_ce         (pe_ce),
    .pe_accumulate (pe_accumulate),
    .pe_weight     (pe_weight),
    .pe_activation (pe_activation),
    .pe_mask       (pe_mask),
    .pe_acc_sum    (pe_acc_sum),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_sum       (res_sum)
`ifdef BNN_FEEDER_DOT_EN
    ,
    .res_dot       (res_dot)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural PE: registered XNOR-popcount accumulator.
  logic [15:0] pe_acc = '0;
  always @(posedge clk) begin
    if (pe_ce)
      pe_acc <= (pe_accumulate ? pe_acc : 16'd0)
              + 16'($countones(~(pe_weight ^ pe_activation) & pe_mask));
  end
  assign pe_acc_sum = pe_acc;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          len;
    logic [63:0] w;
    logic [63:0] a;
    int          gap;
    int          exp_sum;
    int          exp_dot;
    logic [63:0] exp_mask;
  } vec_t;

  task automatic run_job(input string nm, input vec_t v);
    int nw;
    int k;
    nw = (v.len + WS - 1) / WS;
    k  = 0;
    while (!start_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check({nm, " start_ready"}, 64'(start_ready), 64'd1);
    start_valid = 1'b1;
    start_len   = LW'(v.len);
    @(posedge clk); #1;
    start_valid = 1'b0;
    for (int b = 0; b < nw; b++) begin
      if (b > 0) begin
        for (int g = 0; g < v.gap; g++) begin
          @(negedge clk);
          check({nm, " gap pe_ce"}, 64'(pe_ce), 64'd0);
          @(posedge clk); #1;
        end
      end
      rd_valid      = 1'b1;
      rd_weight     = v.w;
      rd_activation = v.a;
      @(negedge clk);
      if (b == 0) begin
        check({nm, " first rd_ready"}, 64'(rd_ready), 64'd1);
        check({nm, " first accumulate"}, 64'(pe_accumulate), 64'd0);
      end else if (b == 1) begin
        check({nm, " second accumulate"}, 64'(pe_accumulate), 64'd1);
      end
      if (b == nw - 1) check({nm, " last mask"}, pe_mask, v.exp_mask);
      @(posedge clk); #1;
      rd_valid      = 1'b0;
      rd_weight     = '0;
      rd_activation = '0;
    end
    @(negedge clk);
    check({nm, " drain pe_ce"}, 64'(pe_ce), 64'd1);
    check({nm, " drain mask"}, pe_mask, 64'd0);
    check({nm, " valid +0"}, 64'(res_valid), 64'd0);
    @(negedge clk);
    check({nm, " capture pe_ce"}, 64'(pe_ce), 64'd0);
    check({nm, " valid +1"}, 64'(res_valid), 64'd0);
    @(negedge clk);
    check({nm, " valid +2"}, 64'(res_valid), 64'd1);
    check({nm, " res_sum"}, 64'(res_sum), 64'(v.exp_sum));
`ifdef BNN_FEEDER_DOT_EN
    check({nm, " res_dot"}, 64'($signed(res_dot)), 64'(longint'(v.exp_dot)));
`endif
    #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    check({nm, " back to idle"}, 64'(start_ready), 64'd1);
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{64,  ONES, ONES, 0, 64,  64,  ONES};
    vecs[1] = '{100, ONES, ONES, 0, 100, 100, 64'h0000_000F_FFFF_FFFF};
    vecs[2] = '{128, 64'hA5A5_A5A5_0F0F_F0F0, 64'h5A5A_5A5A_F0F0_0F0F, 0, 0, -128, ONES};
    vecs[3] = '{128, 64'hA5A5_A5A5_0F0F_F0F0, 64'h5A5A_5A5A_F0F0_0F0F, 3, 0, -128, ONES};
    vecs[4] = '{65,  ONES, ONES, 1, 65,  65,  64'h1};
    vecs[5] = '{64,  ONES, 64'h0F0F_0F0F_0F0F_0F0F, 0, 32, 0, ONES};

    reset = 1'b1; start_valid = 1'b0; start_len = '0;
    rd_valid = 1'b0; rd_weight = '0; rd_activation = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset start_ready", 64'(start_ready), 64'd1);
    check("reset rd_ready", 64'(rd_ready), 64'd0);
    check("reset pe_ce", 64'(pe_ce), 64'd0);
    check("reset res_valid", 64'(res_valid), 64'd0);
    check("reset res_sum", 64'(res_sum), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_job($sformatf("vec%0d", i), vecs[i]);

    // Zero-length job: no PE activity, result on the next cycle, held
    // stable while res_ready stays low.
    start_valid = 1'b1; start_len = '0;
    @(negedge clk);
    check("len0 pe_ce at start", 64'(pe_ce), 64'd0);
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(negedge clk);
    check("len0 res_valid", 64'(res_valid), 64'd1);
    check("len0 res_sum", 64'(res_sum), 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("len0 hold res_valid", 64'(res_valid), 64'd1);
      check("len0 hold res_sum", 64'(res_sum), 64'd0);
      check("len0 hold start_ready", 64'(start_ready), 64'd0);
      check("len0 hold pe_ce", 64'(pe_ce), 64'd0);
    end
    #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("len0 idle", 64'(start_ready), 64'd1);

    // Reset in the middle of a 3-word job, then a clean job must start fresh.
    #1;
    start_valid = 1'b1; start_len = LW'(192);
    @(posedge clk); #1;
    start_valid = 1'b0;
    rd_valid = 1'b1; rd_weight = ONES; rd_activation = ONES;
    @(posedge clk); #1;
    rd_valid = 1'b1;
    @(negedge clk);
    check("mid-job pe_ce before reset", 64'(pe_ce), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check("async reset start_ready", 64'(start_ready), 64'd1);
    check("async reset rd_ready", 64'(rd_ready), 64'd0);
    check("async reset pe_ce", 64'(pe_ce), 64'd0);
    check("async reset pe_mask", pe_mask, 64'd0);
    check("async reset res_valid", 64'(res_valid), 64'd0);
    check("async reset res_sum", 64'(res_sum), 64'd0);
    rd_valid = 1'b0; rd_weight = '0; rd_activation = '0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    run_job("post-reset", vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
